// File: rtl/axi_aw_pkg.sv
// axi_aw_pkg: default AXI write-address widths and the beat struct held in
// the arbiter output slice.
package axi_aw_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_LEN_W  = 4;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
    } aw_beat_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; the first request at or
// after ptr (with wrap-around) wins. Shared by the AW/W/AR arbiters.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    always_comb begin
        int j;
        j = 0;
        grant_idx = '0;
        grant_valid = 1'b0;
        // Walk offsets downward so the offset closest to ptr is the last writer.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant_idx = IW'(j);
                grant_valid = 1'b1;
            end
        end
        grant = (enable && grant_valid) ? (N'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/axi_aw_rr_arbiter.sv
// axi_aw_rr_arbiter: round-robin merge of NUM_REQ AXI AW masters into one
// registered AW slice; a new beat may load in the same cycle the old one leaves.
module axi_aw_rr_arbiter
    import axi_aw_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = AXI_ID_W,
    parameter int ADDR_W  = AXI_ADDR_W,
    parameter int LEN_W   = AXI_LEN_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ*ID_W-1:0]   s_awid,
    input  logic [NUM_REQ*ADDR_W-1:0] s_awaddr,
    input  logic [NUM_REQ*LEN_W-1:0]  s_awlen,
    input  logic [NUM_REQ-1:0]        s_awvalid,
    output logic [NUM_REQ-1:0]        s_awready,
    output logic [ID_W-1:0]           m_awid,
    output logic [ADDR_W-1:0]         m_awaddr,
    output logic [LEN_W-1:0]          m_awlen,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [IDX_W-1:0]          m_grant_idx
);

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   w;
    logic [IDX_W-1:0]   rr_ptr;
    logic               win;
    logic               accept;
    aw_beat_t           beat;
    aw_beat_t           slice;

    // Gating with rst keeps every ready low while reset is held.
    rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_arb (
        .req        (s_awvalid),
        .ptr        (rr_ptr),
        .enable     (rst && (!m_awvalid || m_awready)),
        .grant      (grant),
        .grant_idx  (w),
        .grant_valid(win)
    );

    assign s_awready = grant;
    assign accept    = win && |(grant & s_awvalid);
    assign beat      = '{id:   s_awid[int'(w)*ID_W +: ID_W],
                         addr: s_awaddr[int'(w)*ADDR_W +: ADDR_W],
                         len:  s_awlen[int'(w)*LEN_W +: LEN_W]};

    assign m_awid   = slice.id;
    assign m_awaddr = slice.addr;
    assign m_awlen  = slice.len;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slice       <= '0;
            m_awvalid   <= 1'b0;
            m_grant_idx <= '0;
            rr_ptr      <= '0;
        end else if (accept) begin
            slice       <= beat;
            m_awvalid   <= 1'b1;
            m_grant_idx <= w;
            rr_ptr      <= (w == IDX_W'(NUM_REQ - 1)) ? '0 : w + IDX_W'(1);
        end else if (m_awready) begin
            m_awvalid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_aw_rr_arbiter.sv
// tb_axi_aw_rr_arbiter: directed scenarios plus random traffic, all checked
// against a queue-free reference that tracks the last winner and slice content.
module tb_axi_aw_rr_arbiter;

    localparam int N   = 4;
    localparam int IDW = 4;
    localparam int AW  = 32;
    localparam int LW  = 4;
    localparam int XW  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N*IDW-1:0]  s_awid;
    logic [N*AW-1:0]   s_awaddr;
    logic [N*LW-1:0]   s_awlen;
    logic [N-1:0]      s_awvalid;
    logic [N-1:0]      s_awready;
    logic [IDW-1:0]    m_awid;
    logic [AW-1:0]     m_awaddr;
    logic [LW-1:0]     m_awlen;
    logic              m_awvalid;
    logic              m_awready = 1'b1;
    logic [XW-1:0]     m_grant_idx;

    always #5 clk = ~clk;

    axi_aw_rr_arbiter #(.NUM_REQ(N), .ID_W(IDW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_grant_idx(m_grant_idx)
    );

    int total = 0;
    int bad = 0;

    logic [IDW-1:0] rid[N];
    logic [AW-1:0]  raddr[N];
    logic [LW-1:0]  rlen[N];
    bit             rv[N];

    int             last;
    bit             mv;
    logic [IDW-1:0] mid;
    logic [AW-1:0]  maddr;
    logic [LW-1:0]  mlen;
    int             midx;

    always_comb begin
        s_awid = '0;
        s_awaddr = '0;
        s_awlen = '0;
        s_awvalid = '0;
        for (int i = 0; i < N; i++) begin
            s_awid[i*IDW +: IDW] = rid[i];
            s_awaddr[i*AW +: AW] = raddr[i];
            s_awlen[i*LW +: LW]  = rlen[i];
            s_awvalid[i]         = rv[i];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        last = N - 1;
        mv = 0;
        midx = 0;
        for (int i = 0; i < N; i++) rv[i] = 0;
    endtask

    task automatic req(input int i, input logic [AW-1:0] a, input logic [IDW-1:0] id, input logic [LW-1:0] len);
        rid[i] = id;
        raddr[i] = a;
        rlen[i] = len;
        rv[i] = 1;
    endtask

    // Winner is the nearest valid requester strictly after the last winner.
    function automatic int pick();
        for (int d = 1; d <= N; d++)
            if (rv[(last + d) % N]) return (last + d) % N;
        return -1;
    endfunction

    // Entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit rdy);
        int w;
        logic [N-1:0] exp_rdy;
        m_awready = rdy;
        #1;
        w = (!mv || rdy) ? pick() : -1;
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("s_awready", 64'(s_awready), 64'(exp_rdy));
        check("m_awvalid", 64'(m_awvalid), 64'(mv));
        if (mv) begin
            check("m_awid", 64'(m_awid), 64'(mid));
            check("m_awaddr", 64'(m_awaddr), 64'(maddr));
            check("m_awlen", 64'(m_awlen), 64'(mlen));
            check("m_grant_idx", 64'(m_grant_idx), 64'(midx));
        end
        @(posedge clk);
        #1;
        if (w >= 0) begin
            mv = 1;
            mid = rid[w];
            maddr = raddr[w];
            mlen = rlen[w];
            midx = w;
            last = w;
            rv[w] = 0;
        end else if (rdy) begin
            mv = 0;
        end
    endtask

    task automatic rand_req(input int i);
        req(i, $urandom, IDW'($urandom), LW'($urandom));
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < N; i++) rand_req(i);
        #1;
        check("rst s_awready", 64'(s_awready), 64'(0));
        check("rst m_awvalid", 64'(m_awvalid), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("rst hold s_awready", 64'(s_awready), 64'(0));
        check("rst m_awaddr", 64'(m_awaddr), 64'(0));
        check("rst m_awid", 64'(m_awid), 64'(0));
        check("rst m_awlen", 64'(m_awlen), 64'(0));
        check("rst m_grant_idx", 64'(m_grant_idx), 64'(0));
        rst = 1'b1;

        // All requesters continuously valid: strict 0,1,2,3,0,1 with no bubbles.
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) if (!rv[i]) rand_req(i);
            cycle(1);
            check("rr order", 64'(m_grant_idx), 64'(c % N));
            check("rr no bubble", 64'(m_awvalid), 64'(1));
        end
        for (int i = 0; i < N; i++) rv[i] = 0;
        cycle(1);
        cycle(1);

        req(2, 32'h1000_0040, 4'h5, 4'h3);
        cycle(1);
        check("single addr", 64'(m_awaddr), 64'h1000_0040);
        check("single id", 64'(m_awid), 64'h5);
        check("single len", 64'(m_awlen), 64'h3);
        check("single idx", 64'(m_grant_idx), 64'd2);
        cycle(1);
        cycle(1);

        req(0, 32'h0000_00A0, 4'h1, 4'h0);
        cycle(1);
        req(1, 32'h0000_0B10, 4'h2, 4'h1);
        req(3, 32'h0000_0B30, 4'h3, 4'h2);
        for (int c = 0; c < 5; c++) begin
            cycle(0);
            check("bp hold addr", 64'(m_awaddr), 64'hA0);
            check("bp no ready", 64'(s_awready), 64'(0));
        end
        cycle(1);
        check("bp reload addr", 64'(m_awaddr), 64'hB10);
        check("bp reload valid", 64'(m_awvalid), 64'(1));
        cycle(1);
        cycle(1);

        req(0, 32'h0000_0C00, 4'h4, 4'h1);
        cycle(1);
        req(0, 32'h0000_0D00, 4'h6, 4'h2);
        req(3, 32'h0000_0D30, 4'h7, 4'h3);
        cycle(1);
        check("skip first", 64'(m_grant_idx), 64'd3);
        cycle(1);
        check("skip second", 64'(m_grant_idx), 64'd0);
        req(1, 32'h0000_0E10, 4'h8, 4'h0);
        req(2, 32'h0000_0E20, 4'h9, 4'h0);
        cycle(1);
        check("skip ptr", 64'(m_grant_idx), 64'd1);
        cycle(1);
        cycle(1);
        cycle(1);

        req(2, 32'h0000_F020, 4'hA, 4'h5);
        cycle(1);
        m_awready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("async rst valid", 64'(m_awvalid), 64'(0));
        check("async rst ready", 64'(s_awready), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req(0, 32'h0000_1230, 4'hB, 4'h6);
        cycle(1);
        check("post rst addr", 64'(m_awaddr), 64'h1230);
        check("post rst idx", 64'(m_grant_idx), 64'd0);
        cycle(1);

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if (!rv[i] && $urandom_range(0, 2) == 0) rand_req(i);
            cycle($urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_aw_rr_arbiter.md
Name: axi_aw_rr_arbiter

Overview:
- Shares one AXI write-address (AW) channel slave port, such as sample_dut's SLAVE modport, between NUM_REQ upstream masters.
- Selects among pending requesters with a round-robin arbiter.
- Captures the winner's awid/awaddr/awlen into a single output register slice and drives it downstream with a valid/ready handshake.
- Sits between the master-side AW interfaces and the shared AW slave; full throughput of one transfer per cycle when downstream is always ready.

Parameters:
- NUM_REQ, 4, number of requesting masters; legal range 2..16.
- ID_W, 4, awid width.
- ADDR_W, 32, awaddr width.
- LEN_W, 4, awlen width.
- IDX_W, $clog2(NUM_REQ), width of the grant index (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_awid  input  NUM_REQ*ID_W  per-requester awid, flattened; requester i at [i*ID_W +: ID_W].
- s_awaddr  input  NUM_REQ*ADDR_W  per-requester awaddr, flattened likewise.
- s_awlen  input  NUM_REQ*LEN_W  per-requester awlen, flattened likewise.
- s_awvalid  input  NUM_REQ  per-requester valid.
- s_awready  output  NUM_REQ  per-requester ready; at most one bit high.
- m_awid  output  ID_W  registered awid to the shared slave.
- m_awaddr  output  ADDR_W  registered awaddr.
- m_awlen  output  LEN_W  registered awlen.
- m_awvalid  output  1  registered valid.
- m_awready  input  1  ready from the shared slave.
- m_grant_idx  output  IDX_W  index of the requester whose beat is in the slice.

Behaviour:
- Interface: one clock, clk; reset, rst, is asynchronous and active-low.
- Reset (rst=0, asynchronous assert, release synchronous to clk):
  - m_awvalid=0; m_awid, m_awaddr, m_awlen, m_grant_idx = 0.
  - Round-robin pointer rr_ptr=0.
  - s_awready=0 while rst is low.
- Slice state is FULL when m_awvalid=1, otherwise EMPTY.
- accept_en = !m_awvalid || m_awready (combinational).
- Arbitration (combinational):
  - Search s_awvalid starting at index rr_ptr, ascending with wrap-around modulo NUM_REQ.
  - The first set bit is winner w.
  - No set bit means no winner.
- s_awready[i] = accept_en && winner exists && i==w. Every other bit is 0.
  - s_awready may depend combinationally on s_awvalid and m_awready.
  - s_awready must never be high for a requester whose s_awvalid is low.
- Accept at the clk edge when s_awvalid[w] && s_awready[w]:
  - Load w's id/addr/len into the m_* registers.
  - m_grant_idx <= w; m_awvalid <= 1.
  - rr_ptr <= (w+1) mod NUM_REQ.
- Handshake without accept (m_awvalid && m_awready, no accept that cycle): m_awvalid <= 0.
- Simultaneous handshake and accept: slice reloads with the new beat and m_awvalid stays 1. This gives zero bubbles.
- While FULL and m_awready=0: all m_* outputs hold stable (AXI stability rule) and no accept occurs.
- Latency: request accepted at edge N appears on m_* at edge N (registered); earliest downstream handshake is at edge N+1.
- rr_ptr changes only on accept. Requesters that stay idle never shift it.
- A requester that drops s_awvalid before acceptance is protocol-illegal upstream; it is not checked, and the arbiter re-evaluates every cycle.
- Fairness: a continuously valid requester is accepted within NUM_REQ accepts.
- Reset mid-operation: any beat held in the slice is discarded and rr_ptr returns to 0.
- No FSM beyond the EMPTY/FULL slice bit. The state is m_awvalid plus rr_ptr.

Decomposition:
- Shared package axi_aw_pkg:
  - Default width constants AXI_ID_W=4, AXI_ADDR_W=32, AXI_LEN_W=4.
  - Packed struct aw_beat_t {id, addr, len} used for the slice register.
- Sub-module rr_arbiter (parameters N):
  - Inputs: req[N], ptr, enable.
  - Outputs: grant one-hot[N], grant_idx, grant_valid.
  - Purely combinational; reused for later W-channel and AR-channel arbiters.

Test Plan:
- Reset: hold rst=0 with all s_awvalid=1 → s_awready=0, m_awvalid=0, all m_* = 0. Release rst → first accept goes to requester 0.
- Single requester: only req 2 valid, addr=0x1000_0040, id=0x5, len=3, m_awready=1 → s_awready=4'b0100 for one cycle. Next cycle m_awvalid=1, m_awaddr=0x1000_0040, m_awid=5, m_awlen=3, m_grant_idx=2.
- Round-robin: all four valid continuously, m_awready=1 → grant order 0,1,2,3,0,1 across six consecutive cycles with no idle cycles on m_awvalid.
- Backpressure: slice FULL with addr=0xA0, m_awready=0 for 5 cycles while req 1 and req 3 are valid → m_* stable at 0xA0 and s_awready=0 throughout. When m_awready rises, the next beat loads in the same cycle.
- Pointer skip: rr_ptr=1, only req 0 and req 3 valid → req 3 wins first, then req 0, then rr_ptr=1.
- Mid-operation reset: assert rst low while FULL with m_awready=0 → m_awvalid drops immediately (asynchronous). After release, a new beat from req 0 is accepted and the old beat never appears downstream.
